// File: rtl/fifo_rd_port.sv
// Read-side FIFO controller: read pointer, registered empty/level flags and a FWFT output register.
// Define RD_ALMOST_EMPTY_EN to add the AE_THRESH parameter and the ralmost_empty output.
module fifo_rd_port #(
    parameter int DATASIZE = 32,
    parameter int ADDRSIZE = 4
`ifdef RD_ALMOST_EMPTY_EN
    ,
    parameter int AE_THRESH = 2
`endif
) (
    input  logic                rclk,
    input  logic                rrst,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE-1:0] raddr,
    input  logic [DATASIZE-1:0] rdata,
    output logic [ADDRSIZE:0]   rptr,
    output logic                rempty,
    output logic [DATASIZE-1:0] rd_data,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [ADDRSIZE:0]   rlevel
`ifdef RD_ALMOST_EMPTY_EN
    ,
    output logic                ralmost_empty
`endif
);

    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rbinnext;
    logic [ADDRSIZE:0] rgraynext;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] levelnext;
    logic              fetch;

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b[ADDRSIZE] = g[ADDRSIZE];
        for (int i = ADDRSIZE - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A memory word moves into the output register whenever one exists and the register is free or draining.
    always_comb begin
        fetch     = !rempty && (!rd_valid || rd_ready);
        rbinnext  = rbin + (ADDRSIZE+1)'(fetch);
        rgraynext = (rbinnext >> 1) ^ rbinnext;
        wbin      = gray2bin(rq2_wptr);
        levelnext = wbin - rbinnext;
    end

    assign raddr = rbin[ADDRSIZE-1:0];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin     <= '0;
            rptr     <= '0;
            rempty   <= 1'b1;
            rlevel   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rbin   <= rbinnext;
            rptr   <= rgraynext;
            rempty <= (rgraynext == rq2_wptr);
            rlevel <= levelnext;
            if (fetch) begin
                rd_data  <= rdata;
                rd_valid <= 1'b1;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

`ifdef RD_ALMOST_EMPTY_EN
    always_ff @(posedge rclk) begin
        if (rrst) begin
            ralmost_empty <= 1'b1;
        end else begin
            ralmost_empty <= (int'(levelnext) <= AE_THRESH);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_port.sv
// Directed self-checking bench for fifo_rd_port with a behavioural 16-word memory.
// Also builds with RD_ALMOST_EMPTY_EN defined; the extra flag is only connected.
module tb_fifo_rd_port;

    logic        rclk;
    logic        rrst;
    logic [4:0]  rq2_wptr;
    logic [3:0]  raddr;
    logic [31:0] rdata;
    logic [4:0]  rptr;
    logic        rempty;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rlevel;
`ifdef RD_ALMOST_EMPTY_EN
    logic        ralmost_empty;
`endif

    logic [31:0] mem [0:15];
    int errors;
    int checks;

    fifo_rd_port #(.DATASIZE(32), .ADDRSIZE(4)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .rq2_wptr (rq2_wptr),
        .raddr    (raddr),
        .rdata    (rdata),
        .rptr     (rptr),
        .rempty   (rempty),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rlevel   (rlevel)
`ifdef RD_ALMOST_EMPTY_EN
        ,
        .ralmost_empty (ralmost_empty)
`endif
    );

    assign rdata = mem[raddr];

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [4:0] bin2gray(input int b);
        logic [4:0] x;
        x = b[4:0];
        return x ^ (x >> 1);
    endfunction

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] w);
        rrst     = 1'b1;
        rd_ready = 1'b0;
        rq2_wptr = w;
        tick();
        tick();
        rrst = 1'b0;
    endtask

    task automatic test_reset();
        rrst     = 1'b1;
        rd_ready = 1'b0;
        rq2_wptr = 5'b00011;
        tick();
        tick();
        checks++; if (rempty !== 1'b1) begin errors++; $display("[TB] FAIL reset_rempty: got %b expected 1", rempty); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", rd_valid); end
        checks++; if (rptr !== 5'd0) begin errors++; $display("[TB] FAIL reset_rptr: got %b expected 00000", rptr); end
        checks++; if (rlevel !== 5'd0) begin errors++; $display("[TB] FAIL reset_rlevel: got %0d expected 0", rlevel); end
        checks++; if (raddr !== 4'd0) begin errors++; $display("[TB] FAIL reset_raddr: got %0d expected 0", raddr); end
        checks++; if (rd_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data); end
        rrst = 1'b0;
        tick();
        checks++; if (rempty !== 1'b0) begin errors++; $display("[TB] FAIL release_rempty: got %b expected 0", rempty); end
        checks++; if (rlevel !== 5'd2) begin errors++; $display("[TB] FAIL release_rlevel: got %0d expected 2", rlevel); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_valid: got %b expected 0", rd_valid); end
    endtask

    task automatic test_single_word();
        mem[0] = 32'hDEADBEEF;
        do_reset(5'b00000);
        tick();
        checks++; if (rempty !== 1'b1) begin errors++; $display("[TB] FAIL single_idle_empty: got %b expected 1", rempty); end
        rq2_wptr = 5'b00001;
        tick();
        checks++; if (rempty !== 1'b0) begin errors++; $display("[TB] FAIL single_empty_fall: got %b expected 0", rempty); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %b expected 0", rd_valid); end
        checks++; if (rlevel !== 5'd1) begin errors++; $display("[TB] FAIL single_level1: got %0d expected 1", rlevel); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_word: got v=%b d=%h expected v=1 d=deadbeef", rd_valid, rd_data); end
        checks++; if (rempty !== 1'b1 || rlevel !== 5'd0) begin errors++; $display("[TB] FAIL single_last_empty: got e=%b l=%0d expected e=1 l=0", rempty, rlevel); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_hold: got v=%b d=%h expected v=1 d=deadbeef", rd_valid, rd_data); end
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0 || rempty !== 1'b1) begin errors++; $display("[TB] FAIL single_accept: got v=%b e=%b expected v=0 e=1", rd_valid, rempty); end
        checks++; if (rptr !== 5'b00001 || rd_data !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL single_rptr: got p=%b d=%h expected p=00001 d=deadbeef", rptr, rd_data); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 16; i++) mem[i] = i;
        do_reset(5'b00000);
        rd_ready = 1'b1;
        rq2_wptr = 5'b11000;
        tick();
        checks++; if (rempty !== 1'b0 || rlevel !== 5'd16) begin errors++; $display("[TB] FAIL stream_full: got e=%b l=%0d expected e=0 l=16", rempty, rlevel); end
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== 32'(i)) begin errors++; $display("[TB] FAIL stream_word%0d: got v=%b d=%h expected v=1 d=%h", i, rd_valid, rd_data, 32'(i)); end
        end
        checks++; if (rempty !== 1'b1 || rptr !== 5'b11000 || raddr !== 4'd0) begin errors++; $display("[TB] FAIL stream_end: got e=%b p=%b a=%0d expected e=1 p=11000 a=0", rempty, rptr, raddr); end
        tick();
        rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drain: got %b expected 0", rd_valid); end
    endtask

    task automatic test_back_pressure();
        logic       rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       ev  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int         eidx[6] = '{1, 1, 1, 2, 3, 3};
        int         elev[6] = '{2, 2, 2, 1, 0, 0};
        for (int i = 0; i < 4; i++) mem[i] = 32'hA000_0000 + i;
        do_reset(5'b00000);
        rq2_wptr = bin2gray(4);
        tick();
        checks++; if (rlevel !== 5'd4) begin errors++; $display("[TB] FAIL bp_level4: got %0d expected 4", rlevel); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hA000_0000 || rlevel !== 5'd3) begin errors++; $display("[TB] FAIL bp_first: got v=%b d=%h l=%0d expected v=1 d=a0000000 l=3", rd_valid, rd_data, rlevel); end
        for (int s = 0; s < 6; s++) begin
            rd_ready = rdy[s];
            tick();
            checks++;
            if (rd_valid !== ev[s] || rd_data !== 32'hA000_0000 + eidx[s] || rlevel !== 5'(elev[s])) begin
                errors++;
                $display("[TB] FAIL bp_step%0d: got v=%b d=%h l=%0d expected v=%b d=%h l=%0d", s, rd_valid, rd_data, rlevel, ev[s], 32'hA000_0000 + eidx[s], elev[s]);
            end
        end
        rd_ready = 1'b0;
        checks++; if (rempty !== 1'b1) begin errors++; $display("[TB] FAIL bp_empty: got %b expected 1", rempty); end
    endtask

    task automatic test_wrap();
        int wr = 0;
        int delivered = 0;
        int appear = 0;
        logic [4:0] prev_rptr;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        do_reset(5'b00000);
        prev_rptr = rptr;
        for (int cyc = 0; cyc < 400 && delivered < 40; cyc++) begin
            if (rptr !== prev_rptr) begin
                checks++;
                if ($countones(rptr ^ prev_rptr) != 1) begin errors++; $display("[TB] FAIL wrap_gray_step: got %b after %b expected one-bit change", rptr, prev_rptr); end
            end
            prev_rptr = rptr;
            if (rd_valid && appear < 40 && rd_data === 32'hC000_0000 + appear) begin
                checks++;
                if (rptr !== bin2gray(appear + 1) || raddr !== 4'((appear + 1) % 16)) begin
                    errors++;
                    $display("[TB] FAIL wrap_ptr_word%0d: got p=%b a=%0d expected p=%b a=%0d", appear, rptr, raddr, bin2gray(appear + 1), (appear + 1) % 16);
                end
                appear++;
            end
            rd_ready = (cyc % 7 != 3);
            if (rd_valid && rd_ready) begin
                checks++;
                if (rd_data !== 32'hC000_0000 + delivered) begin errors++; $display("[TB] FAIL wrap_order%0d: got %h expected %h", delivered, rd_data, 32'hC000_0000 + delivered); end
                delivered++;
            end
            if (wr < 40 && wr - delivered < 16) begin
                mem[wr % 16] = 32'hC000_0000 + wr;
                wr++;
                rq2_wptr = bin2gray(wr);
            end
            tick();
        end
        rd_ready = 1'b0;
        checks++; if (delivered != 40 || appear != 40) begin errors++; $display("[TB] FAIL wrap_count: got delivered=%0d seen=%0d expected 40", delivered, appear); end
        checks++; if (rempty !== 1'b1 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_end_flags: got e=%b v=%b expected e=1 v=0", rempty, rd_valid); end
        checks++; if (rptr !== 5'b01100 || raddr !== 4'd8) begin errors++; $display("[TB] FAIL wrap_end_ptr: got p=%b a=%0d expected p=01100 a=8", rptr, raddr); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 6; i++) mem[i] = 32'hB000_0000 + i;
        do_reset(5'b00000);
        rq2_wptr = bin2gray(6);
        tick();
        tick();
        checks++; if (rd_valid !== 1'b1 || rlevel !== 5'd5) begin errors++; $display("[TB] FAIL midrst_setup: got v=%b l=%0d expected v=1 l=5", rd_valid, rlevel); end
        rrst     = 1'b1;
        rd_ready = 1'b1;
        tick();
        rrst = 1'b0;
        checks++; if (rd_valid !== 1'b0 || rptr !== 5'd0 || rd_data !== 32'd0) begin errors++; $display("[TB] FAIL midrst_state: got v=%b p=%b d=%h expected v=0 p=0 d=0", rd_valid, rptr, rd_data); end
        checks++; if (rempty !== 1'b1 || rlevel !== 5'd0) begin errors++; $display("[TB] FAIL midrst_flags: got e=%b l=%0d expected e=1 l=0", rempty, rlevel); end
        tick();
        checks++; if (rempty !== 1'b0 || rlevel !== 5'd6 || rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_recover: got e=%b l=%0d v=%b expected e=0 l=6 v=0", rempty, rlevel, rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hB000_0000 || rptr !== 5'b00001) begin errors++; $display("[TB] FAIL midrst_refetch: got v=%b d=%h p=%b expected v=1 d=b0000000 p=00001", rd_valid, rd_data, rptr); end
        rd_ready = 1'b0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rrst     = 1'b1;
        rd_ready = 1'b0;
        rq2_wptr = 5'b00000;
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        #2;
        test_reset();
        test_single_word();
        test_streaming();
        test_back_pressure();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
